// File: rtl/xpb_lut_bank_if.sv
// rtl/xpb_lut_bank_if.sv - table-write, request and response bus of the lookup bank
//
// Purpose: bundles every non-clock signal of xpb_lut_bank so the bank and
// its driver share one declaration.
//
// Signals:
//   tbl_wr_en/ch/idx/data - table write port (ignored until init_done)
//   in_valid/in_ready     - request handshake, in_idx carries one index per channel
//   out_valid/out_ready   - response handshake, out_data one entry per channel
//   out_sum               - unsigned sum of the channel entries (0 when not built)
//   init_done             - clear sweep finished, bank in service
//
// Modports: master drives requests/writes, slave is the bank itself.
interface xpb_lut_bank_if #(
  parameter int WORD_LEN = 1024,
  parameter int IDX_W    = 5,
  parameter int NUM_CH   = 4,
  parameter int SUM_W    = WORD_LEN + $clog2(NUM_CH),
  parameter int CH_W     = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
);
  logic                       tbl_wr_en;
  logic [CH_W-1:0]            tbl_wr_ch;
  logic [IDX_W-1:0]           tbl_wr_idx;
  logic [WORD_LEN-1:0]        tbl_wr_data;
  logic                       in_valid;
  logic                       in_ready;
  logic [NUM_CH*IDX_W-1:0]    in_idx;
  logic                       out_valid;
  logic                       out_ready;
  logic [NUM_CH*WORD_LEN-1:0] out_data;
  logic [SUM_W-1:0]           out_sum;
  logic                       init_done;

  modport master (
    output tbl_wr_en, tbl_wr_ch, tbl_wr_idx, tbl_wr_data,
    output in_valid, in_idx, out_ready,
    input  in_ready, out_valid, out_data, out_sum, init_done
  );

  modport slave (
    input  tbl_wr_en, tbl_wr_ch, tbl_wr_idx, tbl_wr_data,
    input  in_valid, in_idx, out_ready,
    output in_ready, out_valid, out_data, out_sum, init_done
  );
endinterface

// File: rtl/xpb_lut_bank.sv
// rtl/xpb_lut_bank.sv - multi-channel lookup-table bank with a two-stage read pipeline
//
// Purpose: NUM_CH independent tables, each 2^IDX_W entries of WORD_LEN bits.
// After reset an INIT sweep writes zero into every entry of every channel, one
// index per cycle; only then does the bank accept table writes and lookups.
// One accepted request reads all channels at once; the per-channel entries
// (and optionally their unsigned sum) are presented two cycles later under a
// valid/ready handshake. Entry 0 of every channel is a hard-wired zero.
//
// Ports:
//   clk   - clock, all state on the rising edge
//   rst_n - synchronous active-low reset
//   bus   - xpb_lut_bank_if.slave: table write port, request (in_*),
//           response (out_*), init_done
//
// Build option: XPB_LUT_SUM_EN - when defined, out_sum is the full-width sum
// of the channel entries; when undefined no adder is built and out_sum is 0.
module xpb_lut_bank #(
  parameter int WORD_LEN = 1024,
  parameter int IDX_W    = 5,
  parameter int NUM_CH   = 4,
  parameter int SUM_W    = WORD_LEN + $clog2(NUM_CH),
  parameter int CH_W     = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic          clk,
  input  logic          rst_n,
  xpb_lut_bank_if.slave bus
);

  localparam int DEPTH = 1 << IDX_W;

  typedef enum logic {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  state_t                     r_state;
  state_t                     w_state_nxt;
  logic [IDX_W-1:0]           r_cnt;
  logic [IDX_W-1:0]           w_cnt_nxt;

  // shared table write port: the sweep hits all channels, a user write one
  logic                       w_init_wr;
  logic                       w_user_wr;
  logic [IDX_W-1:0]           w_wr_idx;
  logic [WORD_LEN-1:0]        w_wr_data;

  logic                       w_adv;
  logic                       w_in_ready;
  logic                       w_accept;

  logic                       r_s1_valid;
  logic [NUM_CH*WORD_LEN-1:0] w_s1_data;
  logic                       r_out_valid;
  logic [NUM_CH*WORD_LEN-1:0] r_out_data;

  // ---------------------------------------------------------------- FSM
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= ST_INIT;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_init_wr   = 1'b0;
    w_user_wr   = 1'b0;
    w_wr_idx    = r_cnt;
    w_wr_data   = '0;
    unique case (r_state)
      ST_INIT: begin
        // one entry per cycle on every channel; cnt wraps back to 0 on exit
        w_init_wr = 1'b1;
        w_cnt_nxt = r_cnt + 1'b1;
        if (&r_cnt) begin
          w_state_nxt = ST_RUN;
        end
      end
      ST_RUN: begin
        // entry 0 is the hard-wired zero, so writes aimed at it are dropped
        w_user_wr = bus.tbl_wr_en && (bus.tbl_wr_idx != '0);
        w_wr_idx  = bus.tbl_wr_idx;
        w_wr_data = bus.tbl_wr_data;
      end
      default: begin
        w_state_nxt = ST_INIT;
      end
    endcase
  end

  // ---------------------------------------------------------------- handshake
  // both stages move together; a full output register with no taker stalls all
  assign w_adv      = !r_out_valid || bus.out_ready;
  assign w_in_ready = (r_state == ST_RUN) && w_adv;
  assign w_accept   = bus.in_valid && w_in_ready;

  // ---------------------------------------------------------------- tables + stage 1
  // Storage has no reset so it maps onto RAM; the read is a registered,
  // enabled read so a same-edge write is not seen until the next accept.
  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    logic [WORD_LEN-1:0] r_mem [DEPTH];
    logic [WORD_LEN-1:0] r_s1_word;
    logic [IDX_W-1:0]    w_rd_idx;
    logic                w_we;

    assign w_rd_idx = bus.in_idx[c*IDX_W +: IDX_W];
    assign w_we     = w_init_wr || (w_user_wr && (bus.tbl_wr_ch == CH_W'(c)));

    always_ff @(posedge clk) begin
      if (w_we) begin
        r_mem[w_wr_idx] <= w_wr_data;
      end
      if (w_accept) begin
        r_s1_word <= (w_rd_idx == '0) ? '0 : r_mem[w_rd_idx];
      end
    end

    assign w_s1_data[c*WORD_LEN +: WORD_LEN] = r_s1_word;
  end

  // ---------------------------------------------------------------- stage 2
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_s1_valid  <= 1'b0;
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
    end else if (w_adv) begin
      r_s1_valid  <= w_accept;
      r_out_valid <= r_s1_valid;
      if (r_s1_valid) begin
        r_out_data <= w_s1_data;
      end
    end
  end

`ifdef XPB_LUT_SUM_EN
  logic [SUM_W-1:0] w_sum;
  logic [SUM_W-1:0] r_out_sum;

  // zero-extend every entry first so carries out of WORD_LEN are kept
  always_comb begin
    w_sum = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      w_sum = w_sum + SUM_W'(w_s1_data[c*WORD_LEN +: WORD_LEN]);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_out_sum <= '0;
    end else if (w_adv && r_s1_valid) begin
      r_out_sum <= w_sum;
    end
  end

  assign bus.out_sum = r_out_sum;
`else
  assign bus.out_sum = {SUM_W{1'b0}};
`endif

  assign bus.in_ready  = w_in_ready;
  assign bus.out_valid = r_out_valid;
  assign bus.out_data  = r_out_data;
  assign bus.init_done = (r_state == ST_RUN);

endmodule

// File: doc/xpb_lut_bank.md
XPB_LUT_BANK -- requirements
Module: xpb_lut_bank

Interface
REQ-001 Parameter WORD_LEN, default 1024: width of one table entry in bits.
REQ-002 Parameter IDX_W, default 5: index width per channel; table depth is 2^IDX_W entries.
REQ-003 Parameter NUM_CH, default 4: number of independent lookup channels, each with its own table.
REQ-004 Parameter SUM_W, default WORD_LEN+clog2(NUM_CH): width of out_sum.
REQ-005 The block SHALL use one clock; reset is synchronous and active-low.
REQ-006 clk  in  1  clock; all state updates on the rising edge.
REQ-007 rst_n  in  1  synchronous active-low reset.
REQ-008 tbl_wr_en  in  1  table write strobe.
REQ-009 tbl_wr_ch  in  clog2(NUM_CH)  channel to write.
REQ-010 tbl_wr_idx  in  IDX_W  entry to write.
REQ-011 tbl_wr_data  in  WORD_LEN  entry value.
REQ-012 in_valid  in  1  lookup request valid.
REQ-013 in_ready  out  1  block accepts a request this cycle.
REQ-014 in_idx  in  NUM_CH*IDX_W  per-channel index; channel c is bits [c*IDX_W +: IDX_W].
REQ-015 out_valid  out  1  result valid.
REQ-016 out_ready  in  1  downstream accepts the result.
REQ-017 out_data  out  NUM_CH*WORD_LEN  per-channel entries; channel c is bits [c*WORD_LEN +: WORD_LEN].
REQ-018 out_sum  out  SUM_W  sum of all channel entries.
REQ-019 init_done  out  1  table clear sweep complete.

Function
REQ-020 The FSM SHALL have two states: INIT and RUN.
- INIT: writes zero to entry cnt of every channel each cycle; cnt counts 0 .. 2^IDX_W-1.
- INIT exits to RUN on the cycle after cnt = 2^IDX_W-1.
- RUN is held until reset.
REQ-021 In INIT, in_ready SHALL be 0, init_done SHALL be 0, and tbl_wr_en SHALL be ignored.
REQ-022 In RUN, init_done SHALL be 1.
REQ-023 In RUN, tbl_wr_en=1 SHALL write tbl_wr_data to entry tbl_wr_idx of channel tbl_wr_ch, except that writes to idx 0 are discarded.
REQ-024 Index 0 SHALL always read as zero on every channel.
REQ-025 Pipeline advance condition adv = !out_valid || out_ready.
REQ-026 in_ready SHALL equal adv in RUN.
REQ-027 A request is accepted when in_valid && in_ready.
REQ-028 Stage 1 SHALL register all NUM_CH table reads on accept; stage 2 SHALL register out_data and out_sum.
REQ-029 Latency SHALL be 2 cycles from accept to out_valid when not stalled.
REQ-030 When adv = 0, both stages SHALL hold, and out_data/out_sum SHALL stay stable while out_valid && !out_ready.
REQ-031 Back-to-back accepts SHALL sustain one result per cycle while out_ready = 1.
REQ-032 A write and a read of the same entry in the same cycle SHALL return the old value (read-before-write); the new value is visible from the next accept.
REQ-033 Table writes SHALL be permitted while the pipeline is stalled or busy.
REQ-034 out_sum SHALL be the unsigned, non-truncated sum of the NUM_CH entries; carries are kept in SUM_W and there is no modular reduction.
REQ-035 Table storage SHALL have no reset so that it infers as RAM; clearing is done only by the INIT sweep.

Reset
REQ-036 rst_n = 0 SHALL set the following on the next edge:
- FSM to INIT, cnt = 0;
- stage-1 valid = 0, out_valid = 0;
- out_data = 0, out_sum = 0;
- init_done = 0.
REQ-037 Reset asserted mid-operation SHALL drop in-flight results without emitting them, and SHALL restart the full INIT sweep.

Configuration
REQ-038 Macro XPB_LUT_SUM_EN:
- Defined: out_sum is computed as in REQ-034.
- Undefined: no adder is built, out_sum is tied to 0, and out_data behaviour and 2-cycle latency are unchanged.

Verification
REQ-039 Reset, then idle: init_done rises exactly 32 cycles after rst_n deasserts; in_ready = 0 throughout INIT.
REQ-040 After INIT, with XPB_LUT_SUM_EN defined:
- Stimulus: write ch0 idx3 = 0x5, ch1 idx3 = 0xA, ch2 idx3 = ch3 idx3 = 2^1024-1; then request in_idx = all channels 3.
- Response: out_valid 2 cycles later; out_data holds those four values; out_sum = 2^1025 + 0xD.
REQ-041 Index 0 on all channels after a write attempt of 0xFF to ch0 idx0 -> out_data = 0 and out_sum = 0.
REQ-042 Stream 8 requests with out_ready = 0 for cycles 3-5:
- in_ready drops while stalled;
- out_data is held stable during the stall;
- all 8 results arrive in order with none lost or duplicated.
REQ-043 Same-cycle write ch1 idx7 = 0x2 (old value 0x1) with a read of idx7 -> result 0x1; the next read returns 0x2.
REQ-044 rst_n asserted with 2 results in flight -> out_valid = 0 the next cycle, neither result appears, and a fresh INIT sweep completes.
